// File: rtl/axis_loopback_pkg.sv
// Shared constants, store-and-forward state type and pointer-width helper for
// the AXI-Stream loopback FIFO.
package axis_loopback_pkg;

  localparam int C_AXIS_WIDTH = 8;
  localparam int C_FIFO_DEPTH = 16;
  localparam int C_PKT_CNT_W  = 16;

  typedef enum logic {
    SF_STORE = 1'b0,
    SF_CUT   = 1'b1
  } sf_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple-dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module axis_fifo_mem
  import axis_loopback_pkg::*;
#(
  parameter int c_WIDTH = C_AXIS_WIDTH,
  parameter int c_DEPTH = C_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [clog2(c_DEPTH)-1:0] wr_addr,
  input  logic [c_WIDTH:0]          wr_data,
  input  logic [clog2(c_DEPTH)-1:0] rd_addr,
  output logic [c_WIDTH:0]          rd_data
);

  logic [c_WIDTH:0] mem_q [c_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_loopback_fifo.sv
// AXI-Stream loopback through a registered-output FWFT FIFO with packet counter.
// Optional store-and-forward mode: define AXIS_LOOPBACK_STORE_FWD_EN.
//
// state    | meaning (store-and-forward build only)
// SF_STORE | hold output until a complete packet is buffered
// SF_CUT   | FIFO full with no complete packet; behave as cut-through
module axis_loopback_fifo
  import axis_loopback_pkg::*;
#(
  parameter int c_WIDTH = C_AXIS_WIDTH,
  parameter int c_DEPTH = C_FIFO_DEPTH,
  parameter int c_CNT_W = C_PKT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [c_WIDTH-1:0]      s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [c_WIDTH-1:0]      m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [clog2(c_DEPTH):0] occupancy,
  output logic [c_CNT_W-1:0]      pkt_count
);

  localparam int AW = clog2(c_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(c_DEPTH);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      occ_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [c_WIDTH:0]   head_q, head_d;
  logic [c_WIDTH:0]   mem_rd_data;
  logic [c_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic               push, pop, pop_last;

  axis_fifo_mem #(
    .c_WIDTH (c_WIDTH),
    .c_DEPTH (c_DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    push     = s_axis_tvalid && s_ready_q;
    pop      = m_valid_q && m_axis_tready;
    pop_last = pop && head_q[c_WIDTH];
    wr_ptr_d = wr_ptr_q + (push ? PW'(1) : '0);
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : '0);
    occ_d    = wr_ptr_d - rd_ptr_d;
    s_ready_d = (occ_d < DEPTH_P);
    // The next head may be the beat being written this edge; bypass the array.
    head_d = head_q;
    if (occ_d != '0) begin
      head_d = (push && (rd_ptr_d == wr_ptr_q)) ? {s_axis_tlast, s_axis_tdata}
                                                : mem_rd_data;
    end
    pkt_count_d = pkt_count_q + (pop_last ? c_CNT_W'(1) : '0);
  end

`ifdef AXIS_LOOPBACK_STORE_FWD_EN
  logic [PW-1:0] cplt_q, cplt_d;
  sf_state_e     state_q, state_d;
  logic          push_last;

  always_comb begin
    push_last = push && s_axis_tlast;
    cplt_d    = cplt_q;
    if (push_last && !pop_last) begin
      cplt_d = cplt_q + PW'(1);
    end else if (!push_last && pop_last) begin
      cplt_d = cplt_q - PW'(1);
    end

    state_d = state_q;
    case (state_q)
      SF_STORE: if ((wr_ptr_q - rd_ptr_q) == DEPTH_P && cplt_q == '0) state_d = SF_CUT;
      SF_CUT:   if (pop_last) state_d = SF_STORE;
      default:  state_d = SF_STORE;
    endcase

    m_valid_d = (occ_d != '0) && ((cplt_d != '0) || (state_d == SF_CUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cplt_q  <= '0;
      state_q <= SF_STORE;
    end else begin
      cplt_q  <= cplt_d;
      state_q <= state_d;
    end
  end
`else
  always_comb begin
    m_valid_d = (occ_d != '0);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      head_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      head_q      <= head_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = head_q[c_WIDTH-1:0];
  assign m_axis_tlast  = head_q[c_WIDTH];
  assign occupancy     = wr_ptr_q - rd_ptr_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Bench for axis_loopback_fifo: queue-based reference model with random traffic;
// store-and-forward scenarios when AXIS_LOOPBACK_STORE_FWD_EN is defined.
module tb_axis_loopback_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [4:0]  occupancy;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;

  logic [8:0]  model_q[$];
  logic [8:0]  last_head = '0;
  logic [15:0] exp_pkt = '0;
  logic        exp_rdy = 1'b0;

  axis_loopback_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .occupancy     (occupancy),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tready"}, s_axis_tready, 0);
    check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
    check_eq({tag, "_tdata"},  m_axis_tdata, 0);
    check_eq({tag, "_tlast"},  m_axis_tlast, 0);
    check_eq({tag, "_occ"},    occupancy, 0);
    check_eq({tag, "_pkt"},    pkt_count, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    check_eq("rel_tready_low", s_axis_tready, 0);
    @(posedge clk);
    #1;
    check_eq("rel_tready_high", s_axis_tready, 1);
    check_eq("rel_tvalid", m_axis_tvalid, 0);
    exp_rdy = 1'b1;
  endtask

  // One clock of traffic: check outputs against the model, apply inputs, advance.
  task automatic step(input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
    logic push, pop;
    logic [8:0] popped;
    @(negedge clk);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    s_axis_tlast  = sl;
    m_axis_tready = mr;
    check_eq("tready", s_axis_tready, exp_rdy);
    check_eq("tvalid", m_axis_tvalid, model_q.size() != 0);
    check_eq("occupancy", occupancy, model_q.size());
    check_eq("pkt_count", pkt_count, exp_pkt);
    check_eq("tdata", m_axis_tdata, last_head[7:0]);
    check_eq("tlast", m_axis_tlast, last_head[8]);
    push = sv && exp_rdy;
    pop  = (model_q.size() != 0) && mr;
    @(posedge clk);
    if (pop) begin
      popped = model_q.pop_front();
      if (popped[8]) exp_pkt = exp_pkt + 16'd1;
    end
    if (push) model_q.push_back({sl, sd});
    exp_rdy = (model_q.size() < 16);
    if (model_q.size() != 0) last_head = model_q[0];
  endtask

`ifdef AXIS_LOOPBACK_STORE_FWD_EN
  logic [8:0] src_q[$];
  logic [8:0] got_q[$];

  task automatic sf_cycle();
    logic acc;
    @(negedge clk);
    if (src_q.size() != 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0][7:0];
      s_axis_tlast  = src_q[0][8];
    end else begin
      s_axis_tvalid = 1'b0;
    end
    acc = s_axis_tvalid && s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
    @(posedge clk);
    if (acc) src_q.delete(0);
  endtask
`endif

  initial begin
    int idx;
    logic sv, sl, mr;
    logic [7:0] sd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

`ifndef AXIS_LOOPBACK_STORE_FWD_EN
    // Streaming with an always-ready sink.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), i == 16, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("stream_pkt", pkt_count, 1);

    // Fill against a stalled sink: source holds each beat until accepted.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      sv = (idx < 20);
      step(sv, 8'(8'hA0 + idx), 1'b0, 1'b0);
      if (sv && model_q.size() > 0 && model_q[model_q.size()-1][7:0] == 8'(8'hA0 + idx)) idx++;
    end
    @(negedge clk);
    check_eq("full_occ", occupancy, 16);
    check_eq("full_tready", s_axis_tready, 0);
    check_eq("full_accepted", idx, 16);
    for (int c = 0; c < 20; c++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic with varying backpressure intensity.
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 100; c++) begin
        sv = ($urandom_range(0, 3) != 0);
        sd = 8'($urandom);
        sl = ($urandom_range(0, 4) == 0);
        mr = ($urandom_range(0, seg + 1) == 0);
        step(sv, sd, sl, mr);
      end
    end
    for (int c = 0; c < 20; c++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Packet 0x11..0x15 under random backpressure.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), i == 4, $urandom_range(0, 1) == 1);
    for (int c = 0; c < 30; c++) step(1'b0, 8'h00, 1'b0, $urandom_range(0, 1) == 1);
    check_eq("bp_drained", occupancy, 0);

    // Reset in the middle of a 6-beat packet.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_q.delete();
    last_head = '0;
    exp_pkt   = '0;
    exp_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h70 + i), i == 5, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("midrst_pkt", pkt_count, 1);
`else
    // Output held back until the tlast beat is buffered.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(8'h30 + i);
      s_axis_tlast  = (i == 3);
      check_eq("sf_tready", s_axis_tready, 1);
      @(posedge clk);
      #1;
      check_eq("sf_tvalid", m_axis_tvalid, i == 3);
    end
    for (int c = 0; c < 20 && got_q.size() < 4; c++) sf_cycle();
    check_eq("sf_got", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++)
      check_eq("sf_beat", got_q[i], {i == 3, 8'(8'h30 + i)});
    @(negedge clk);
    check_eq("sf_pkt", pkt_count, 1);

    // No tlast: fallback to cut-through once the FIFO is full.
    got_q.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) src_q.push_back({1'b0, 8'(8'h40 + i)});
    for (int c = 0; c < 20; c++) sf_cycle();
    @(negedge clk);
    check_eq("cut_occ", occupancy, 16);
    check_eq("cut_tready", s_axis_tready, 0);
    check_eq("cut_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 60 && got_q.size() < 17; c++) sf_cycle();
    check_eq("cut_got", got_q.size(), 17);
    for (int i = 0; i < got_q.size() && i < 17; i++)
      check_eq("cut_beat", got_q[i], {1'b0, 8'(8'h40 + i)});
    @(negedge clk);
    check_eq("cut_empty", occupancy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
